// File: rtl/mem_cache_pkg.sv
// Shared types and address-field helpers for the direct-mapped cache.
package mem_cache_pkg;

  // Byte offset bits inside a 32-bit word.
  localparam int WORD_OFF = 2;

  typedef enum logic [1:0] {
    IDLE,
    RD_WAIT,
    WR_WAIT
  } cache_state_t;

  // Line index field; callers cast the result down to their index width.
  function automatic logic [31:0] adr_index(input logic [31:0] adr, input int idx_w);
    return (adr >> WORD_OFF) & ((32'd1 << idx_w) - 32'd1);
  endfunction

  // Tag field: everything above the index.
  function automatic logic [31:0] adr_tag(input logic [31:0] adr, input int idx_w);
    return adr >> (WORD_OFF + idx_w);
  endfunction

endpackage

// File: rtl/cache_line_store.sv
// Valid/tag/data storage: one write port, one combinational read port,
// flush-all of the valid bits. Only valid bits are reset.
module cache_line_store
  import mem_cache_pkg::*;
#(
  parameter int LINES = 16,
  parameter int IDX_W = $clog2(LINES),
  parameter int TAG_W = 32 - IDX_W - WORD_OFF
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_flush_all,
  input  logic             i_we,
  input  logic [IDX_W-1:0] i_widx,
  input  logic [TAG_W-1:0] i_wtag,
  input  logic [31:0]      i_wdata,
  input  logic [IDX_W-1:0] i_ridx,
  output logic             o_rvalid,
  output logic [TAG_W-1:0] o_rtag,
  output logic [31:0]      o_rdata
);

  logic [LINES-1:0]             r_valid;
  logic [LINES-1:0][TAG_W-1:0]  r_tag;
  logic [LINES-1:0][31:0]       r_data;

  // Valid bits: flush wins over a same-edge fill so a flushed fill ends invalid.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)         r_valid         <= '0;
    else if (i_flush_all) r_valid         <= '0;
    else if (i_we)        r_valid[i_widx] <= 1'b1;
  end

  // Tag/data arrays carry no reset; valid gates their use.
  always_ff @(posedge i_clk) begin
    if (i_we) begin
      r_tag[i_widx]  <= i_wtag;
      r_data[i_widx] <= i_wdata;
    end
  end

  assign o_rvalid = r_valid[i_ridx];
  assign o_rtag   = r_tag[i_ridx];
  assign o_rdata  = r_data[i_ridx];

endmodule

// File: rtl/mem_cache.sv
// Direct-mapped, write-through, no-write-allocate, one-word-line cache
// between the core memory port and a req/ack main memory.
module mem_cache
  import mem_cache_pkg::*;
#(
  parameter int LINES = 16,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cpu_req,
  input  logic             cpu_we,
  input  logic [31:0]      cpu_adr,
  input  logic [31:0]      cpu_wdata,
  output logic [31:0]      cpu_rdata,
  output logic             cpu_stall,
  input  logic             flush,
  output logic             mem_req,
  output logic             mem_we,
  output logic [31:0]      mem_adr,
  output logic [31:0]      mem_wdata,
  input  logic [31:0]      mem_rdata,
  input  logic             mem_ack,
  output logic [CNT_W-1:0] hit_cnt,
  output logic [CNT_W-1:0] miss_cnt
);

  localparam int IDX_W = $clog2(LINES);
  localparam int TAG_W = 32 - IDX_W - WORD_OFF;

  cache_state_t r_state;
  logic         r_flush_pend;

  logic [IDX_W-1:0] w_cpu_idx, w_mem_idx, w_ridx;
  logic [TAG_W-1:0] w_cpu_tag, w_mem_tag, w_cmp_tag, w_ltag;
  logic [31:0]      w_ldata;
  logic             w_lvalid, w_line_match, w_in_idle;
  logic             w_rd_hit, w_rd_miss, w_wr, w_rd_ack, w_wr_ack;
  logic             w_st_we, w_flush_all;

  assign w_cpu_idx = IDX_W'(adr_index(cpu_adr, IDX_W));
  assign w_cpu_tag = TAG_W'(adr_tag(cpu_adr, IDX_W));
  assign w_mem_idx = IDX_W'(adr_index(mem_adr, IDX_W));
  assign w_mem_tag = TAG_W'(adr_tag(mem_adr, IDX_W));

  // In IDLE the lookup uses the live core address; while waiting it uses the
  // latched address so a write-hit update targets the line that was issued.
  assign w_in_idle    = (r_state == IDLE);
  assign w_ridx       = w_in_idle ? w_cpu_idx : w_mem_idx;
  assign w_cmp_tag    = w_in_idle ? w_cpu_tag : w_mem_tag;
  assign w_line_match = w_lvalid && (w_ltag == w_cmp_tag);

  assign w_rd_hit  = w_in_idle && cpu_req && !cpu_we && w_line_match;
  assign w_rd_miss = w_in_idle && cpu_req && !cpu_we && !w_line_match;
  assign w_wr      = w_in_idle && cpu_req && cpu_we;
  assign w_rd_ack  = (r_state == RD_WAIT) && mem_ack;
  assign w_wr_ack  = (r_state == WR_WAIT) && mem_ack;

  // Fill on read ack; write-through updates only a line already present.
  assign w_st_we     = w_rd_ack || (w_wr_ack && w_line_match);
  // Flush seen during a wait is deferred to the ack edge so it also kills the fill.
  assign w_flush_all = (w_in_idle && flush) ||
                       ((w_rd_ack || w_wr_ack) && (r_flush_pend || flush));

  cache_line_store #(.LINES(LINES)) u_store (
    .i_clk      (clk),
    .i_rst_n    (reset),
    .i_flush_all(w_flush_all),
    .i_we       (w_st_we),
    .i_widx     (w_mem_idx),
    .i_wtag     (w_mem_tag),
    .i_wdata    (w_rd_ack ? mem_rdata : mem_wdata),
    .i_ridx     (w_ridx),
    .o_rvalid   (w_lvalid),
    .o_rtag     (w_ltag),
    .o_rdata    (w_ldata)
  );

  // Core-facing stall and read data; both resolve in the same cycle.
  always_comb begin
    cpu_stall = 1'b0;
    cpu_rdata = '0;
    case (r_state)
      IDLE: begin
        cpu_stall = w_rd_miss || w_wr;
        if (w_rd_hit) cpu_rdata = w_ldata;
      end
      RD_WAIT: begin
        cpu_stall = !mem_ack;
        if (mem_ack) cpu_rdata = mem_rdata;
      end
      WR_WAIT: cpu_stall = !mem_ack;
      default: cpu_stall = 1'b0;
    endcase
  end

  // Miss/write FSM and registered memory handshake.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= IDLE;
      r_flush_pend <= 1'b0;
      mem_req      <= 1'b0;
      mem_we       <= 1'b0;
      mem_adr      <= '0;
      mem_wdata    <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          r_flush_pend <= 1'b0;
          if (w_rd_miss) begin
            mem_adr <= {cpu_adr[31:2], 2'b00};
            mem_req <= 1'b1;
            mem_we  <= 1'b0;
            r_state <= RD_WAIT;
          end else if (w_wr) begin
            mem_adr   <= {cpu_adr[31:2], 2'b00};
            mem_wdata <= cpu_wdata;
            mem_req   <= 1'b1;
            mem_we    <= 1'b1;
            r_state   <= WR_WAIT;
          end
        end
        RD_WAIT, WR_WAIT: begin
          if (mem_ack) begin
            mem_req      <= 1'b0;
            mem_we       <= 1'b0;
            r_flush_pend <= 1'b0;
            r_state      <= IDLE;
          end else if (flush) begin
            r_flush_pend <= 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Read hit/miss statistics, saturating at all-ones.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hit_cnt  <= '0;
      miss_cnt <= '0;
    end else begin
      if (w_rd_hit && (hit_cnt != '1))   hit_cnt  <= hit_cnt + CNT_W'(1);
      if (w_rd_miss && (miss_cnt != '1)) miss_cnt <= miss_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_mem_cache.sv
// Directed bench for mem_cache with a small req/ack memory responder.
module tb_mem_cache;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cpu_req = 1'b0, cpu_we = 1'b0, flush = 1'b0, mem_ack = 1'b0;
  logic [31:0] cpu_adr = '0, cpu_wdata = '0, mem_rdata = '0;
  logic [31:0] cpu_rdata, mem_adr, mem_wdata;
  logic        cpu_stall, mem_req, mem_we;
  logic [15:0] hit_cnt, miss_cnt;

  int total = 0;
  int bad   = 0;

  logic [31:0] mem_model [logic [31:0]];
  int          n_rd = 0, n_wr = 0;
  bit          auto_ack = 1'b1;
  int          lat = 3;
  int          rcnt = 0;

  mem_cache #(.LINES(16), .CNT_W(16)) dut (
    .clk(clk), .reset(rst_n),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_adr(cpu_adr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall), .flush(flush),
    .mem_req(mem_req), .mem_we(mem_we), .mem_adr(mem_adr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
  );

  always #5 clk = ~clk;

  // Memory: ack lands 'lat' cycles after the first cycle mem_req is seen high.
  initial forever begin
    @(posedge clk); #1;
    if (!auto_ack) rcnt = 0;
    else if (!rst_n) begin rcnt = 0; mem_ack = 1'b0; end
    else if (mem_ack) begin mem_ack = 1'b0; rcnt = 0; end
    else if (mem_req) begin
      rcnt++;
      if (rcnt > lat) begin
        mem_ack = 1'b1;
        if (mem_we) begin mem_model[mem_adr] = mem_wdata; n_wr++; end
        else begin
          mem_rdata = mem_model.exists(mem_adr) ? mem_model[mem_adr] : 32'h0;
          n_rd++;
        end
      end
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  // One core access held until the stall drops; flush pulses in cycle flush_at.
  task automatic cpu_access(input logic we, input logic [31:0] adr, input logic [31:0] wd,
                            input int flush_at, output int stalls, output logic [31:0] rd,
                            output logic [31:0] req_adr, output logic req_we);
    int k = 0;
    bit done = 0;
    @(posedge clk); #1;
    cpu_req = 1'b1; cpu_we = we; cpu_adr = adr; cpu_wdata = wd; flush = (flush_at == 0);
    stalls = 0; rd = 'x; req_adr = '0; req_we = 1'b0;
    while (!done && k < 100) begin
      @(negedge clk);
      if (mem_req) begin req_adr = mem_adr; req_we = mem_we; end
      if (!cpu_stall) begin rd = cpu_rdata; done = 1; end
      else begin
        stalls++; k++;
        @(posedge clk); #1;
        flush = (k == flush_at);
      end
    end
    if (!done) begin total++; bad++; $display("FAIL access_timeout adr=%h", adr); end
    @(posedge clk); #1;
    cpu_req = 1'b0; cpu_we = 1'b0; flush = 1'b0;
  endtask

  task automatic test_reset();
    #12;
    total++; if (mem_req !== 1'b0)    begin bad++; $display("FAIL rst_mem_req got=%b want=0", mem_req); end
    total++; if (mem_we !== 1'b0)     begin bad++; $display("FAIL rst_mem_we got=%b want=0", mem_we); end
    total++; if (mem_adr !== 32'h0)   begin bad++; $display("FAIL rst_mem_adr got=%h want=0", mem_adr); end
    total++; if (mem_wdata !== 32'h0) begin bad++; $display("FAIL rst_mem_wdata got=%h want=0", mem_wdata); end
    total++; if (hit_cnt !== 16'h0)   begin bad++; $display("FAIL rst_hit got=%h want=0", hit_cnt); end
    total++; if (miss_cnt !== 16'h0)  begin bad++; $display("FAIL rst_miss got=%h want=0", miss_cnt); end
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    total++; if (cpu_stall !== 1'b0)  begin bad++; $display("FAIL idle_stall got=%b want=0", cpu_stall); end
    total++; if (cpu_rdata !== 32'h0) begin bad++; $display("FAIL idle_rdata got=%h want=0", cpu_rdata); end
  endtask

  task automatic test_cold_read();
    int st; logic [31:0] rd, ra; logic rw;
    mem_model[32'h10] = 32'hDEADBEEF;
    cpu_access(1'b0, 32'h10, 32'h0, -1, st, rd, ra, rw);
    total++; if (st !== 4)              begin bad++; $display("FAIL cold_stall got=%0d want=4", st); end
    total++; if (rd !== 32'hDEADBEEF)   begin bad++; $display("FAIL cold_data got=%h want=deadbeef", rd); end
    total++; if (ra !== 32'h10)         begin bad++; $display("FAIL cold_mem_adr got=%h want=10", ra); end
    total++; if (miss_cnt !== 16'd1)    begin bad++; $display("FAIL cold_miss got=%0d want=1", miss_cnt); end
    cpu_access(1'b0, 32'h10, 32'h0, -1, st, rd, ra, rw);
    total++; if (st !== 0)              begin bad++; $display("FAIL hit_stall got=%0d want=0", st); end
    total++; if (rd !== 32'hDEADBEEF)   begin bad++; $display("FAIL hit_data got=%h want=deadbeef", rd); end
    total++; if (hit_cnt !== 16'd1)     begin bad++; $display("FAIL hit_cnt got=%0d want=1", hit_cnt); end
    total++; if (n_rd !== 1)            begin bad++; $display("FAIL hit_memrd got=%0d want=1", n_rd); end
  endtask

  task automatic test_conflict();
    int st; logic [31:0] rd, ra; logic rw;
    mem_model[32'h50] = 32'hCAFE0050;
    cpu_access(1'b0, 32'h50, 32'h0, -1, st, rd, ra, rw);
    total++; if (rd !== 32'hCAFE0050) begin bad++; $display("FAIL conf_a got=%h want=cafe0050", rd); end
    cpu_access(1'b0, 32'h10, 32'h0, -1, st, rd, ra, rw);
    total++; if (st !== 4 || rd !== 32'hDEADBEEF) begin bad++; $display("FAIL conf_b got=%0d/%h want=4/deadbeef", st, rd); end
    cpu_access(1'b0, 32'h50, 32'h0, -1, st, rd, ra, rw);
    total++; if (st !== 4 || rd !== 32'hCAFE0050) begin bad++; $display("FAIL conf_c got=%0d/%h want=4/cafe0050", st, rd); end
    total++; if (miss_cnt !== 16'd4) begin bad++; $display("FAIL conf_miss got=%0d want=4", miss_cnt); end
    total++; if (n_rd !== 4)         begin bad++; $display("FAIL conf_memrd got=%0d want=4", n_rd); end
  endtask

  task automatic test_write();
    int st; logic [31:0] rd, ra; logic rw;
    cpu_access(1'b1, 32'h50, 32'h12345678, -1, st, rd, ra, rw);
    total++; if (st !== 4)          begin bad++; $display("FAIL wr_stall got=%0d want=4", st); end
    total++; if (rw !== 1'b1 || ra !== 32'h50) begin bad++; $display("FAIL wr_req got=%b/%h want=1/50", rw, ra); end
    total++; if (mem_model[32'h50] !== 32'h12345678) begin bad++; $display("FAIL wr_mem got=%h want=12345678", mem_model[32'h50]); end
    cpu_access(1'b0, 32'h50, 32'h0, -1, st, rd, ra, rw);
    total++; if (st !== 0 || rd !== 32'h12345678) begin bad++; $display("FAIL wr_hit_rd got=%0d/%h want=0/12345678", st, rd); end
    cpu_access(1'b1, 32'h90, 32'hA5A5A5A5, -1, st, rd, ra, rw);
    total++; if (n_wr !== 2)        begin bad++; $display("FAIL wr_miss_memwr got=%0d want=2", n_wr); end
    cpu_access(1'b0, 32'h50, 32'h0, -1, st, rd, ra, rw);
    total++; if (st !== 0 || rd !== 32'h12345678) begin bad++; $display("FAIL no_alloc_keep got=%0d/%h want=0/12345678", st, rd); end
    cpu_access(1'b0, 32'h90, 32'h0, -1, st, rd, ra, rw);
    total++; if (st !== 4 || rd !== 32'hA5A5A5A5) begin bad++; $display("FAIL no_alloc_miss got=%0d/%h want=4/a5a5a5a5", st, rd); end
    total++; if (hit_cnt !== 16'd3 || miss_cnt !== 16'd5) begin bad++; $display("FAIL wr_cnts got=%0d/%0d want=3/5", hit_cnt, miss_cnt); end
  endtask

  task automatic test_flush();
    int st; logic [31:0] rd, ra; logic rw;
    mem_model[32'h20] = 32'h20202020;
    cpu_access(1'b0, 32'h20, 32'h0, 2, st, rd, ra, rw);
    total++; if (st !== 4 || rd !== 32'h20202020) begin bad++; $display("FAIL flw_rd got=%0d/%h want=4/20202020", st, rd); end
    cpu_access(1'b0, 32'h20, 32'h0, -1, st, rd, ra, rw);
    total++; if (st !== 4) begin bad++; $display("FAIL flw_after got=%0d want=4", st); end
    cpu_access(1'b0, 32'h20, 32'h0, 0, st, rd, ra, rw);
    total++; if (st !== 0 || rd !== 32'h20202020) begin bad++; $display("FAIL fli_same got=%0d/%h want=0/20202020", st, rd); end
    cpu_access(1'b0, 32'h20, 32'h0, -1, st, rd, ra, rw);
    total++; if (st !== 4) begin bad++; $display("FAIL fli_after got=%0d want=4", st); end
    total++; if (hit_cnt !== 16'd4 || miss_cnt !== 16'd8) begin bad++; $display("FAIL fl_cnts got=%0d/%0d want=4/8", hit_cnt, miss_cnt); end
  endtask

  task automatic test_reset_mid();
    int st; logic [31:0] rd, ra; logic rw;
    auto_ack = 1'b0; mem_ack = 1'b0;
    @(posedge clk); #1; cpu_req = 1'b1; cpu_we = 1'b0; cpu_adr = 32'h30;
    @(posedge clk); @(posedge clk); @(negedge clk);
    total++; if (mem_req !== 1'b1) begin bad++; $display("FAIL rm_pre_req got=%b want=1", mem_req); end
    #1 rst_n = 1'b0; #1;
    total++; if (mem_req !== 1'b0 || mem_adr !== 32'h0) begin bad++; $display("FAIL rm_req got=%b/%h want=0/0", mem_req, mem_adr); end
    total++; if (hit_cnt !== 16'h0 || miss_cnt !== 16'h0) begin bad++; $display("FAIL rm_cnts got=%0d/%0d want=0/0", hit_cnt, miss_cnt); end
    cpu_req = 1'b0; #1;
    total++; if (cpu_stall !== 1'b0) begin bad++; $display("FAIL rm_stall got=%b want=0", cpu_stall); end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1; mem_ack = 1'b1; mem_rdata = 32'hBAD0BAD0;
    @(negedge clk);
    total++; if (cpu_rdata !== 32'h0 || cpu_stall !== 1'b0) begin bad++; $display("FAIL rm_late_ack got=%h/%b want=0/0", cpu_rdata, cpu_stall); end
    @(posedge clk); #1; mem_ack = 1'b0;
    @(negedge clk);
    total++; if (mem_req !== 1'b0 || miss_cnt !== 16'h0) begin bad++; $display("FAIL rm_idle got=%b/%0d want=0/0", mem_req, miss_cnt); end
    auto_ack = 1'b1;
    cpu_access(1'b0, 32'h10, 32'h0, -1, st, rd, ra, rw);
    total++; if (st !== 4 || rd !== 32'hDEADBEEF) begin bad++; $display("FAIL rm_reread got=%0d/%h want=4/deadbeef", st, rd); end
    total++; if (miss_cnt !== 16'd1 || hit_cnt !== 16'd0) begin bad++; $display("FAIL rm_reread_cnt got=%0d/%0d want=1/0", miss_cnt, hit_cnt); end
  endtask

  task automatic test_saturate();
    @(posedge clk); #1; cpu_req = 1'b1; cpu_we = 1'b0; cpu_adr = 32'h10;
    repeat (65535) @(posedge clk);
    #1;
    total++; if (hit_cnt !== 16'hFFFF) begin bad++; $display("FAIL sat_reach got=%h want=ffff", hit_cnt); end
    repeat (5) @(posedge clk);
    #1;
    total++; if (hit_cnt !== 16'hFFFF) begin bad++; $display("FAIL sat_hold got=%h want=ffff", hit_cnt); end
    total++; if (miss_cnt !== 16'd1)   begin bad++; $display("FAIL sat_miss got=%0d want=1", miss_cnt); end
    cpu_req = 1'b0;
  endtask

  initial begin
    test_reset();
    test_cold_read();
    test_conflict();
    test_write();
    test_flush();
    test_reset_mid();
    test_saturate();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_cache.md
Name: mem_cache

Overview:
- Direct-mapped, write-through, no-write-allocate, one-word-line cache.
- Sits between the multicycle ARM core's memory port (Adr/WriteData/MemWrite/ReadData) and a slower main memory with a req/ack handshake.
- Read hits return data in zero cycles, combinationally, like the existing single-cycle memory.
- Misses and all writes assert cpu_stall; the core freezes its state-machine advance and enables while cpu_stall is high.

Parameters:
- LINES, 16, number of cache lines; power of 2, at least 2. IDX_W = clog2(LINES).
- CNT_W, 16, width of the hit and miss statistics counters.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- cpu_req  input  1  core access valid this cycle.
- cpu_we  input  1  1 = write (the core's MemWrite), 0 = read.
- cpu_adr  input  32  byte address; bits [1:0] ignored (word aligned).
- cpu_wdata  input  32  write data.
- cpu_rdata  output  32  read data (combinational).
- cpu_stall  output  1  core must hold its request and state (combinational).
- flush  input  1  invalidate all lines.
- mem_req  output  1  registered memory request.
- mem_we  output  1  registered memory write enable.
- mem_adr  output  32  registered word-aligned address.
- mem_wdata  output  32  registered write data.
- mem_rdata  input  32  memory read data, valid when mem_ack=1.
- mem_ack  input  1  one-cycle completion pulse.
- hit_cnt  output  CNT_W  read hits, saturating.
- miss_cnt  output  CNT_W  read misses, saturating.

Behaviour:
- Address split: index = cpu_adr[IDX_W+1:2], tag = cpu_adr[31:IDX_W+2]. Each line holds valid, tag and a 32-bit data word.
- hit = cpu_req & valid[index] & (tag_store[index] == tag).
- Reset (reset=0, asynchronous):
  - state = IDLE; all valid bits = 0.
  - mem_req = mem_we = 0; mem_adr = mem_wdata = 0.
  - hit_cnt = miss_cnt = 0.
  - Tag/data arrays are not reset.
- Reset mid-transaction aborts the transaction. Any ack that arrives after reset releases is ignored in IDLE.

FSM states: IDLE, RD_WAIT, WR_WAIT.
- IDLE, read hit:
  - cpu_rdata = line data; cpu_stall = 0; hit_cnt += 1.
- IDLE, read miss:
  - cpu_stall = 1; miss_cnt += 1.
  - Latch mem_adr = {cpu_adr[31:2], 2'b00}; mem_req <= 1, mem_we <= 0; go to RD_WAIT.
- IDLE, write (hit or miss):
  - cpu_stall = 1.
  - Latch mem_adr and mem_wdata; mem_req <= 1, mem_we <= 1; go to WR_WAIT.
- RD_WAIT:
  - cpu_stall = 1 while mem_ack = 0; mem_req stays high.
  - On mem_ack: cpu_stall = 0 and cpu_rdata = mem_rdata in that same cycle. Fill the line (valid=1, tag, data) at the edge; mem_req <= 0; go to IDLE.
- WR_WAIT:
  - cpu_stall = 1 until mem_ack.
  - On mem_ack: cpu_stall = 0. If the line hits on the latched address, update its data (no allocate on a miss). mem_req <= 0; go to IDLE.
- Miss latency:
  - mem_req rises on the edge after the miss cycle.
  - Total stall = 1 + cycles until ack, counting the ack cycle as the release.
- cpu_rdata = 0 when neither a hit in IDLE nor an ack in RD_WAIT.
- Counters saturate at all-ones and do not wrap. A read miss counts once, not again on the fill.
- flush:
  - In IDLE, clears all valid bits at the edge. A read in that same cycle is still served using pre-flush state.
  - In RD_WAIT/WR_WAIT, flush is recorded and applied on the ack edge, after the fill, so the filled line also ends up invalid.
- mem_ack while in IDLE is ignored.
- cpu_req = 0 in IDLE: no stall, no counter change.

Decomposition:
- Package mem_cache_pkg holds:
  - state enum cache_state_t {IDLE, RD_WAIT, WR_WAIT};
  - the address-field helper functions (index/tag extraction);
  - the WORD_OFF = 2 constant.
- One sub-module, cache_line_store:
  - valid/tag/data arrays; async-clear of valid; flush-all; single write port.
  - Combinational read of valid/tag/data at an index.
- The FSM, handshake registers and counters live in mem_cache.

Test Plan:
- Cold read of 0x00000010, mem acks 3 cycles after mem_req rises with 0xDEADBEEF -> cpu_stall high 4 cycles, mem_adr=0x10, cpu_rdata=0xDEADBEEF on the ack cycle, miss_cnt=1. Re-read 0x10 -> zero stall, 0xDEADBEEF, hit_cnt=1.
- Conflict (LINES=16): read 0x10, then 0x50 (same index 4), then 0x10 -> three misses, miss_cnt=3, three mem reads.
- Write hit to 0x10 with 0x12345678 -> mem write issued (mem_we=1); after ack, read 0x10 hits and returns 0x12345678. Write miss to 0x90, then read 0x90 -> read misses (no allocate).
- flush asserted during RD_WAIT for 0x20 -> core gets data on the ack cycle; next read of 0x20 misses.
- Reset driven low mid RD_WAIT -> mem_req=0 and state IDLE immediately; late mem_ack ignored; counters 0; read of 0x10 misses.
- Drive hits 65,536 times with CNT_W=16 -> hit_cnt stays at 0xFFFF.
